// File: rtl/eeg_aram_rd_sched.sv
// eeg_aram_rd_sched: read-port scheduler for one ARAM bank.
//
// Shares the bank's address channel (ARAM_ADD_*) and data channel (ARAM_DAT_*) among
// REQ_NUM requesters. Whole bursts (address beats up to and including LST) are granted
// round-robin. Every accepted address beat pushes the granted requester index into a tag
// FIFO. Returning data beats are routed to the requester at the FIFO head.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   IS_IDLE                     arbiter idle and no reads outstanding
//   STS_ERR                     sticky: bank returned data with no outstanding tag
//   REQ_ADD_VLD/LST/RDY/ADD     per-requester address channels (ADD packed REQ_NUM*ADD_AW)
//   REQ_DAT_VLD/LST/RDY         per-requester data handshake (VLD one-hot or zero)
//   REQ_DAT_DAT                 shared data bus to all requesters
//   ARAM_ADD_VLD/LST/RDY/ADD    address channel to the bank
//   ARAM_DAT_VLD/LST/RDY/DAT    data channel from the bank
//
// Build option: define EEG_ARAM_SCHED_FIXPRI_EN for fixed priority (lowest index wins);
// the round-robin pointer then stays at 0.
module eeg_aram_rd_sched #(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned ADD_AW    = 12,
    parameter int unsigned DAT_DW    = 8,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      IS_IDLE,
    output logic                      STS_ERR,
    input  logic [REQ_NUM-1:0]        REQ_ADD_VLD,
    input  logic [REQ_NUM-1:0]        REQ_ADD_LST,
    output logic [REQ_NUM-1:0]        REQ_ADD_RDY,
    input  logic [REQ_NUM*ADD_AW-1:0] REQ_ADD_ADD,
    output logic [REQ_NUM-1:0]        REQ_DAT_VLD,
    output logic [REQ_NUM-1:0]        REQ_DAT_LST,
    input  logic [REQ_NUM-1:0]        REQ_DAT_RDY,
    output logic [DAT_DW-1:0]         REQ_DAT_DAT,
    output logic                      ARAM_ADD_VLD,
    output logic                      ARAM_ADD_LST,
    input  logic                      ARAM_ADD_RDY,
    output logic [ADD_AW-1:0]         ARAM_ADD_ADD,
    input  logic                      ARAM_DAT_VLD,
    input  logic                      ARAM_DAT_LST,
    output logic                      ARAM_DAT_RDY,
    input  logic [DAT_DW-1:0]         ARAM_DAT_DAT
);

    localparam int unsigned TAG_W = $clog2(REQ_NUM);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] gnt_q, gnt_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] tag_mem_q [TAG_DEPTH];
    logic [TAG_W-1:0] tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sts_err_q, sts_err_d;

    logic             full, empty, push, pop;
    logic [TAG_W-1:0] head, pick, idx;
    logic             found;
    int unsigned      rr_base;

    assign full    = (cnt_q == CNT_W'(TAG_DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = tag_mem_q[rd_ptr_q];
    assign IS_IDLE = (state_q == StIdle) && empty;
    assign STS_ERR = sts_err_q;

    // First valid requester scanning upward from the base, wrapping modulo REQ_NUM.
    always_comb begin
`ifdef EEG_ARAM_SCHED_FIXPRI_EN
        rr_base = 0;
`else
        rr_base = 32'(rr_ptr_q);
`endif
        pick  = gnt_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            idx = TAG_W'((rr_base + k) % REQ_NUM);
            if (!found && REQ_ADD_VLD[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Burst FSM and address forwarding.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_ptr_d     = rr_ptr_q;
        REQ_ADD_RDY  = '0;
        ARAM_ADD_VLD = 1'b0;
        ARAM_ADD_LST = 1'b0;
        ARAM_ADD_ADD = '0;
        push         = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Grant is registered only; the bank sees nothing this cycle.
                if (|REQ_ADD_VLD) begin
                    gnt_d   = pick;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                ARAM_ADD_VLD       = REQ_ADD_VLD[gnt_q] & ~full;
                ARAM_ADD_LST       = REQ_ADD_LST[gnt_q];
                ARAM_ADD_ADD       = REQ_ADD_ADD[32'(gnt_q)*ADD_AW +: ADD_AW];
                REQ_ADD_RDY[gnt_q] = ARAM_ADD_RDY & ~full;
                push               = REQ_ADD_VLD[gnt_q] & ARAM_ADD_RDY & ~full;
                if (push && REQ_ADD_LST[gnt_q]) begin
                    state_d = StIdle;
`ifndef EEG_ARAM_SCHED_FIXPRI_EN
                    rr_ptr_d = TAG_W'((32'(gnt_q) + 32'd1) % REQ_NUM);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tag FIFO and data return routing.
    always_comb begin
        REQ_DAT_VLD  = '0;
        REQ_DAT_LST  = '0;
        REQ_DAT_DAT  = ARAM_DAT_DAT;
        ARAM_DAT_RDY = ~empty & REQ_DAT_RDY[head];
        pop          = ARAM_DAT_VLD & ARAM_DAT_RDY;
        if (!empty) begin
            REQ_DAT_VLD[head] = ARAM_DAT_VLD;
            REQ_DAT_LST[head] = ARAM_DAT_LST;
        end

        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = gnt_q;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        sts_err_d = sts_err_q | (ARAM_DAT_VLD & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            sts_err_q <= 1'b0;
            for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            sts_err_q <= sts_err_d;
            tag_mem_q <= tag_mem_d;
        end
    end

endmodule

// File: tb/tb_eeg_aram_rd_sched.sv
// Self-checking bench for eeg_aram_rd_sched: requester and bank models plus an address
// and data scoreboard, driven from one initial block.
module tb_eeg_aram_rd_sched;

    localparam int unsigned REQ_NUM   = 4;
    localparam int unsigned ADD_AW    = 12;
    localparam int unsigned DAT_DW    = 8;
    localparam int unsigned TAG_DEPTH = 4;
    localparam int unsigned TAG_W     = $clog2(REQ_NUM);

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      IS_IDLE, STS_ERR;
    logic [REQ_NUM-1:0]        REQ_ADD_VLD, REQ_ADD_LST, REQ_ADD_RDY;
    logic [REQ_NUM*ADD_AW-1:0] REQ_ADD_ADD;
    logic [REQ_NUM-1:0]        REQ_DAT_VLD, REQ_DAT_LST, REQ_DAT_RDY;
    logic [DAT_DW-1:0]         REQ_DAT_DAT;
    logic                      ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_RDY;
    logic [ADD_AW-1:0]         ARAM_ADD_ADD;
    logic                      ARAM_DAT_VLD, ARAM_DAT_LST, ARAM_DAT_RDY;
    logic [DAT_DW-1:0]         ARAM_DAT_DAT;

    eeg_aram_rd_sched #(
        .REQ_NUM  (REQ_NUM),
        .ADD_AW   (ADD_AW),
        .DAT_DW   (DAT_DW),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IS_IDLE     (IS_IDLE),
        .STS_ERR     (STS_ERR),
        .REQ_ADD_VLD (REQ_ADD_VLD),
        .REQ_ADD_LST (REQ_ADD_LST),
        .REQ_ADD_RDY (REQ_ADD_RDY),
        .REQ_ADD_ADD (REQ_ADD_ADD),
        .REQ_DAT_VLD (REQ_DAT_VLD),
        .REQ_DAT_LST (REQ_DAT_LST),
        .REQ_DAT_RDY (REQ_DAT_RDY),
        .REQ_DAT_DAT (REQ_DAT_DAT),
        .ARAM_ADD_VLD(ARAM_ADD_VLD),
        .ARAM_ADD_LST(ARAM_ADD_LST),
        .ARAM_ADD_RDY(ARAM_ADD_RDY),
        .ARAM_ADD_ADD(ARAM_ADD_ADD),
        .ARAM_DAT_VLD(ARAM_DAT_VLD),
        .ARAM_DAT_LST(ARAM_DAT_LST),
        .ARAM_DAT_RDY(ARAM_DAT_RDY),
        .ARAM_DAT_DAT(ARAM_DAT_DAT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0]  req;
        logic [ADD_AW-1:0] addr;
        logic              lst;
    } add_exp_t;

    typedef struct packed {
        logic [TAG_W-1:0]  req;
        logic [DAT_DW-1:0] dat;
        logic              lst;
    } dat_exp_t;

    typedef struct packed {
        logic [DAT_DW-1:0] dat;
        logic              lst;
    } bank_t;

    add_exp_t exp_add_q[$];
    dat_exp_t exp_dat_q[$];
    bank_t    bank_q[$];

    // Requester model: beats left, burst length, position in burst, next address.
    int unsigned       left [REQ_NUM];
    int unsigned       blen [REQ_NUM];
    int unsigned       pos  [REQ_NUM];
    logic [ADD_AW-1:0] raddr[REQ_NUM];

    // Bank model: returns addr[7:0] as data, one beat per cycle when enabled.
    logic              bank_en, spurious, bank_have, bank_lst;
    logic [DAT_DW-1:0] bank_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
        assign REQ_ADD_VLD[g]                  = (left[g] != 0);
        assign REQ_ADD_LST[g]                  = (pos[g] + 1 == blen[g]);
        assign REQ_ADD_ADD[g*ADD_AW +: ADD_AW] = raddr[g];
    end
    assign ARAM_DAT_VLD = spurious | (bank_en & bank_have);
    assign ARAM_DAT_DAT = bank_dat;
    assign ARAM_DAT_LST = bank_lst;

    // One clock: scoreboard at the falling edge, model update just after the rising edge.
    task automatic tick();
        logic [REQ_NUM-1:0] acc_vec, oh, oh_l;
        add_exp_t ea;
        dat_exp_t ed;
        bank_t    bb;
        @(negedge clk);
        acc_vec = '0;
        if (!rst_n) begin
            exp_add_q.delete();
            exp_dat_q.delete();
            bank_q.delete();
            for (int i = 0; i < REQ_NUM; i++) begin
                left[i] = 0;
                pos[i]  = 0;
            end
        end else begin
            acc_vec = REQ_ADD_VLD & REQ_ADD_RDY;
            if (ARAM_DAT_VLD && ARAM_DAT_RDY) begin
                pop_cnt++;
                if (bank_q.size() != 0) bb = bank_q.pop_front();
                n_tests++;
                if (exp_dat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dat_unexpected: got vld=%b, want no delivery", REQ_DAT_VLD);
                end else begin
                    ed      = exp_dat_q.pop_front();
                    oh      = '0;
                    oh_l    = '0;
                    oh[ed.req]   = 1'b1;
                    oh_l[ed.req] = ed.lst;
                    if (REQ_DAT_VLD !== oh || REQ_DAT_LST !== oh_l || REQ_DAT_DAT !== ed.dat) begin
                        n_fail++;
                        $display("FAIL dat_route: got vld=%b lst=%b dat=%h, want vld=%b lst=%b dat=%h",
                                 REQ_DAT_VLD, REQ_DAT_LST, REQ_DAT_DAT, oh, oh_l, ed.dat);
                    end
                end
            end
            if (ARAM_ADD_VLD && ARAM_ADD_RDY) begin
                acc_cnt++;
                bb.dat = ARAM_ADD_ADD[DAT_DW-1:0];
                bb.lst = ARAM_ADD_LST;
                bank_q.push_back(bb);
                n_tests++;
                if (exp_add_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL add_unexpected: got addr=%h, want no beat", ARAM_ADD_ADD);
                end else begin
                    ea     = exp_add_q.pop_front();
                    oh     = '0;
                    oh[ea.req] = 1'b1;
                    if (ARAM_ADD_ADD !== ea.addr || ARAM_ADD_LST !== ea.lst || acc_vec !== oh) begin
                        n_fail++;
                        $display("FAIL add_beat: got addr=%h lst=%b acc=%b, want addr=%h lst=%b acc=%b",
                                 ARAM_ADD_ADD, ARAM_ADD_LST, acc_vec, ea.addr, ea.lst, oh);
                    end
                    ed.req = ea.req;
                    ed.dat = ea.addr[DAT_DW-1:0];
                    ed.lst = ea.lst;
                    exp_dat_q.push_back(ed);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (acc_vec[i] && left[i] != 0) begin
                left[i]  = left[i] - 1;
                raddr[i] = raddr[i] + 1'b1;
                pos[i]   = (pos[i] + 1 == blen[i]) ? 0 : pos[i] + 1;
            end
        end
        bank_have = (bank_q.size() != 0);
        if (bank_have) begin
            bank_dat = bank_q[0].dat;
            bank_lst = bank_q[0].lst;
        end
        #1;
    endtask

    task automatic push_exp(input int r, input logic [ADD_AW-1:0] a, input logic l);
        add_exp_t e;
        e.req  = TAG_W'(r);
        e.addr = a;
        e.lst  = l;
        exp_add_q.push_back(e);
    endtask

    // Start a requester; optionally queue its beats as the next expected ones.
    task automatic load_req(input int r, input int n, input int bl, input logic [ADD_AW-1:0] a,
                            input bit add_exp);
        if (add_exp) begin
            for (int b = 0; b < n; b++) begin
                push_exp(r, a + ADD_AW'(b), ((b % bl) == bl - 1));
            end
        end
        blen[r]  = bl;
        pos[r]   = 0;
        raddr[r] = a;
        left[r]  = n;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (exp_add_q.size() == 0 && exp_dat_q.size() == 0 && IS_IDLE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_n = 1'b0;
        #1;
        got = {IS_IDLE, STS_ERR, ARAM_ADD_VLD, ARAM_DAT_RDY, |REQ_ADD_RDY, |REQ_DAT_VLD};
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL reset_value[%0d]: got %b, want %b", i, got[i], (i == 5));
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        bit ok;
        for (int i = 0; i < REQ_NUM; i++) begin
            load_req(i, 2, 1, ADD_AW'(i << 8), 1'b0);
        end
`ifdef EEG_ARAM_SCHED_FIXPRI_EN
        for (int i = 0; i < REQ_NUM; i++)
            for (int k = 0; k < 2; k++) push_exp(i, ADD_AW'((i << 8) + k), 1'b1);
`else
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < REQ_NUM; i++) push_exp(i, ADD_AW'((i << 8) + k), 1'b1);
`endif
        #1;
        n_tests++;
        if (ARAM_ADD_VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle_bubble: got %b, want 0", ARAM_ADD_VLD);
        end
        wait_drain(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d beats pending, want 0", exp_add_q.size());
        end
    endtask

    task automatic test_single_burst();
        bit ok;
        load_req(1, 3, 3, 12'h010, 1'b1);
        #1;
        n_tests++;
        if (ARAM_ADD_VLD !== 1'b0 || REQ_ADD_RDY !== '0) begin
            n_fail++;
            $display("FAIL single_idle: got vld=%b rdy=%b, want 0/0", ARAM_ADD_VLD, REQ_ADD_RDY);
        end
        wait_drain(ok);
        n_tests++;
        if (!ok || left[1] != 0) begin
            n_fail++;
            $display("FAIL single_is_idle: got is_idle=%b, want 1", IS_IDLE);
        end
    endtask

    task automatic test_fifo_full();
        int acc0, pop0;
        bit ok;
        bank_en = 1'b0;
        acc0    = acc_cnt;
        pop0    = pop_cnt;
        load_req(0, 6, 6, 12'h200, 1'b1);
        repeat (6) tick();
        n_tests++;
        if (acc_cnt - acc0 != 4 || REQ_ADD_RDY[0] !== 1'b0 || ARAM_ADD_VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: got acc=%0d rdy=%b vld=%b, want 4/0/0",
                     acc_cnt - acc0, REQ_ADD_RDY[0], ARAM_ADD_VLD);
        end
        bank_en = 1'b1;
        #1;
        n_tests++;
        if (ARAM_DAT_RDY !== 1'b1 || ARAM_ADD_VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got dat_rdy=%b add_vld=%b, want 1/0",
                     ARAM_DAT_RDY, ARAM_ADD_VLD);
        end
        tick();
        bank_en = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (acc_cnt - acc0 != 5 || pop_cnt - pop0 != 1 || ARAM_ADD_VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL full_one_more: got acc=%0d pop=%0d vld=%b, want 5/1/0",
                     acc_cnt - acc0, pop_cnt - pop0, ARAM_ADD_VLD);
        end
        bank_en = 1'b1;
        wait_drain(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_drain: got %0d data pending, want 0", exp_dat_q.size());
        end
    endtask

    task automatic test_data_order();
        int pop0;
        bit ok;
        bank_en     = 1'b0;
        REQ_DAT_RDY = 4'b1011;
        load_req(2, 2, 2, 12'h3a0, 1'b1);
        repeat (4) tick();
        load_req(0, 2, 2, 12'h4b0, 1'b1);
        repeat (4) tick();
        bank_en = 1'b1;
        pop0    = pop_cnt;
        #1;
        n_tests++;
        if (ARAM_DAT_RDY !== 1'b0 || REQ_DAT_VLD !== 4'b0100) begin
            n_fail++;
            $display("FAIL order_block: got dat_rdy=%b vld=%b, want 0/0100", ARAM_DAT_RDY, REQ_DAT_VLD);
        end
        repeat (2) tick();
        n_tests++;
        if (pop_cnt != pop0 || REQ_DAT_VLD[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL order_hold: got pops=%0d vld0=%b, want 0/0", pop_cnt - pop0, REQ_DAT_VLD[0]);
        end
        REQ_DAT_RDY = '1;
        wait_drain(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL order_drain: got %0d data pending, want 0", exp_dat_q.size());
        end
    endtask

    task automatic test_spurious();
        spurious = 1'b1;
        #1;
        n_tests++;
        if (ARAM_DAT_RDY !== 1'b0 || STS_ERR !== 1'b0 || REQ_DAT_VLD !== '0) begin
            n_fail++;
            $display("FAIL spur_now: got rdy=%b err=%b vld=%b, want 0/0/0",
                     ARAM_DAT_RDY, STS_ERR, REQ_DAT_VLD);
        end
        tick();
        n_tests++;
        if (STS_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_set: got %b, want 1", STS_ERR);
        end
        spurious = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (STS_ERR !== 1'b1 || IS_IDLE !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_sticky: got err=%b idle=%b, want 1/1", STS_ERR, IS_IDLE);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc0;
        bit ok;
        bank_en = 1'b0;
        acc0    = acc_cnt;
        load_req(3, 4, 4, 12'h5c0, 1'b1);
        repeat (3) tick();
        n_tests++;
        if (acc_cnt - acc0 != 2) begin
            n_fail++;
            $display("FAIL mid_accepted: got %0d, want 2", acc_cnt - acc0);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (IS_IDLE !== 1'b1 || STS_ERR !== 1'b0 || ARAM_ADD_VLD !== 1'b0 || ARAM_DAT_RDY !== 1'b0 ||
            REQ_ADD_RDY !== '0 || REQ_DAT_VLD !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got idle=%b err=%b avld=%b drdy=%b ardy=%b dvld=%b, want 1/0/0/0/0/0",
                     IS_IDLE, STS_ERR, ARAM_ADD_VLD, ARAM_DAT_RDY, REQ_ADD_RDY, REQ_DAT_VLD);
        end
        tick();
        tick();
        rst_n = 1'b1;
        bank_en = 1'b1;
        load_req(0, 1, 1, 12'h600, 1'b1);
        load_req(3, 1, 1, 12'h7d0, 1'b1);
        wait_drain(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_regrant: got %0d beats pending, want 0", exp_add_q.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ARAM_ADD_RDY = 1'b1;
        REQ_DAT_RDY  = '1;
        bank_en      = 1'b1;
        spurious     = 1'b0;
        bank_have    = 1'b0;
        bank_dat     = '0;
        bank_lst     = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            left[i]  = 0;
            blen[i]  = 1;
            pos[i]   = 0;
            raddr[i] = '0;
        end
        test_reset();
        test_round_robin();
        test_single_burst();
        test_fifo_full();
        test_data_order();
        test_spurious();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
